instr_encoder: RTL

INSTR_ENCODER -- requirements
Module: instr_encoder

---
 rtl/instr_encoder.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/instr_encoder.sv
// instr_encoder: turns register-level encode requests into RV32I instruction
// words and streams them into an instruction memory through a one-cycle write
// strobe.
//
// Optional feature: define INSTR_ENCODER_JAL_EN to accept req_op 101 (JAL).
// Without the macro, op 101 is treated as an illegal request like any other
// undefined opcode.
//
// state | meaning
// ------+----------------------------------------------------------------
// IDLE  | waiting for a request; req_ready high unless full or clearing
// ENC   | captured fields are encoded and legality checked
// WR    | imem_we high for exactly this cycle; address/count advance after
module instr_encoder #(
   parameter int ADDR_W = 6
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              clear,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [2:0]        req_op,
   input  logic [2:0]        req_alu,
   input  logic [4:0]        req_rd,
   input  logic [4:0]        req_rs1,
   input  logic [4:0]        req_rs2,
   input  logic [31:0]       req_imm,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [31:0]       imem_wdata,
   output logic [ADDR_W:0]   word_count,
   output logic              full,
   output logic              err
);

   localparam logic [ADDR_W:0]   DEPTH_V  = (ADDR_W+1)'(1) << ADDR_W;
   localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
   localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);

   localparam logic [2:0] OP_LW   = 3'b000;
   localparam logic [2:0] OP_SW   = 3'b001;
   localparam logic [2:0] OP_R    = 3'b010;
   localparam logic [2:0] OP_BEQ  = 3'b011;
   localparam logic [2:0] OP_ADDI = 3'b100;
`ifdef INSTR_ENCODER_JAL_EN
   localparam logic [2:0] OP_JAL  = 3'b101;
`endif

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ENC  = 2'd1,
      S_WR   = 2'd2
   } state_t;

   state_t state;

   logic [2:0]  op_q;
   logic [2:0]  alu_q;
   logic [4:0]  rd_q;
   logic [4:0]  rs1_q;
   logic [4:0]  rs2_q;
   logic [31:0] imm_q;

   logic        enc_legal;
   logic [31:0] enc_word;
   logic        imm12_ok;
   logic        br13_ok;
   logic signed [31:0] imm_s;
   logic [2:0]  r_funct3;
   logic        r_sub;
   logic        r_ok;
`ifdef INSTR_ENCODER_JAL_EN
   logic        jal_ok;
`endif

   // Ready is purely a function of the current state, fill level and clear.
   assign req_ready = (state == S_IDLE) && !full && !clear;

   // Full once every word of the memory has been written; never wraps.
   assign full = (word_count == DEPTH_V);

   assign imm_s = imm_q;

   // Immediate range checks for the I/S formats and the branch offset.
   always_comb begin
      imm12_ok = (imm_s >= -32'sd2048) && (imm_s <= 32'sd2047);
      br13_ok  = (imm_s >= -32'sd4096) && (imm_s <= 32'sd4094) && !imm_q[0];
`ifdef INSTR_ENCODER_JAL_EN
      jal_ok   = (imm_s >= -32'sd1048576) && (imm_s <= 32'sd1048574) && !imm_q[0];
`endif
   end

   // Map the ALUControl code to RV32I funct3 / funct7 selector.
   always_comb begin
      r_funct3 = 3'b000;
      r_sub    = 1'b0;
      r_ok     = 1'b1;
      case (alu_q)
         3'b000: r_funct3 = 3'b000;
         3'b001: begin
            r_funct3 = 3'b000;
            r_sub    = 1'b1;
         end
         3'b010: r_funct3 = 3'b111;
         3'b011: r_funct3 = 3'b110;
         3'b101: r_funct3 = 3'b010;
         default: r_ok = 1'b0;
      endcase
   end

   // Build the instruction word and its legality from the captured fields.
   always_comb begin
      enc_word  = 32'h0000_0000;
      enc_legal = 1'b0;
      case (op_q)
         OP_LW: begin
            enc_word  = {imm_q[11:0], rs1_q, 3'b010, rd_q, 7'b0000011};
            enc_legal = imm12_ok;
         end
         OP_SW: begin
            enc_word  = {imm_q[11:5], rs2_q, rs1_q, 3'b010, imm_q[4:0], 7'b0100011};
            enc_legal = imm12_ok;
         end
         OP_R: begin
            enc_word  = {1'b0, r_sub, 5'b00000, rs2_q, rs1_q, r_funct3, rd_q, 7'b0110011};
            enc_legal = r_ok;
         end
         OP_BEQ: begin
            enc_word  = {imm_q[12], imm_q[10:5], rs2_q, rs1_q, 3'b000,
                         imm_q[4:1], imm_q[11], 7'b1100011};
            enc_legal = br13_ok;
         end
         OP_ADDI: begin
            enc_word  = {imm_q[11:0], rs1_q, 3'b000, rd_q, 7'b0010011};
            enc_legal = imm12_ok;
         end
`ifdef INSTR_ENCODER_JAL_EN
         OP_JAL: begin
            enc_word  = {imm_q[20], imm_q[10:1], imm_q[11], imm_q[19:12], rd_q, 7'b1101111};
            enc_legal = jal_ok;
         end
`endif
         default: begin
            enc_word  = 32'h0000_0000;
            enc_legal = 1'b0;
         end
      endcase
   end

   // Sequencer: capture, encode, write; clear aborts anything in flight.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= S_IDLE;
         op_q       <= 3'b000;
         alu_q      <= 3'b000;
         rd_q       <= 5'd0;
         rs1_q      <= 5'd0;
         rs2_q      <= 5'd0;
         imm_q      <= 32'h0000_0000;
         imem_we    <= 1'b0;
         imem_addr  <= '0;
         imem_wdata <= 32'h0000_0000;
         word_count <= '0;
         err        <= 1'b0;
      end else if (clear) begin
         state      <= S_IDLE;
         imem_we    <= 1'b0;
         imem_addr  <= '0;
         word_count <= '0;
         err        <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               imem_we <= 1'b0;
               if (req_valid && req_ready) begin
                  op_q  <= req_op;
                  alu_q <= req_alu;
                  rd_q  <= req_rd;
                  rs1_q <= req_rs1;
                  rs2_q <= req_rs2;
                  imm_q <= req_imm;
                  state <= S_ENC;
               end
            end
            S_ENC: begin
               if (enc_legal) begin
                  imem_wdata <= enc_word;
                  imem_we    <= 1'b1;
                  state      <= S_WR;
               end else begin
                  err   <= 1'b1;
                  state <= S_IDLE;
               end
            end
            S_WR: begin
               imem_we    <= 1'b0;
               imem_addr  <= imem_addr + ADDR_ONE;
               word_count <= word_count + CNT_ONE;
               state      <= S_IDLE;
            end
            default: begin
               imem_we <= 1'b0;
               state   <= S_IDLE;
            end
         endcase
      end
   end

endmodule
